sc_matrix_frame_compositor: RTL and testbench

//  Parametrised, double-buffered frame compositor for the 8x8 MAX7219 game display. Holds

---
 rtl/sc_matrix_frame_compositor.sv | 151 +++++++++++++++
 tb/tb_sc_matrix_frame_compositor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_matrix_frame_compositor.sv
// Double-buffered bit-plane compositor for the 8x8 MAX7219 game display: back-buffer row writes,
// frame-synchronous swap, column-transposed readout and a post-swap collision/goal scan.
module sc_matrix_frame_compositor #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int LAYERS = 3,
  parameter int AW     = 3
) (
  input  logic              SC_FRAMECOMP_CLOCK_50,
  input  logic              SC_FRAMECOMP_RESET_InLow,
  input  logic [LAYERS-1:0] SC_FRAMECOMP_wrLayer_In,
  input  logic [AW-1:0]     SC_FRAMECOMP_wrRow_In,
  input  logic [COLS-1:0]   SC_FRAMECOMP_wrData_In,
  input  logic              SC_FRAMECOMP_swap_In,
  input  logic [1:0]        SC_FRAMECOMP_mode_In,
  input  logic [AW-1:0]     SC_FRAMECOMP_dispAddr_In,
  output logic [ROWS-1:0]   SC_FRAMECOMP_dispData_Out,
  output logic              SC_FRAMECOMP_swapReady_Out,
  output logic              SC_FRAMECOMP_swapPending_Out,
  output logic              SC_FRAMECOMP_checkDone_Out,
  output logic              SC_FRAMECOMP_collision_Out,
  output logic              SC_FRAMECOMP_goal_Out
);

  localparam bit HAS_GOAL   = (LAYERS >= 3);
  localparam int GOAL_LAYER = HAS_GOAL ? 2 : 0;

  typedef enum logic [1:0] {IDLE, PENDING, SCAN, DONE} stateT;

  stateT state, nextState;

  logic [1:0][LAYERS-1:0][ROWS-1:0][COLS-1:0] frameBuf;
  logic            frontSel, backSel;
  logic [AW-1:0]   prevAddr, scanRow;
  logic            hitAcc, goalAcc, rowHit, rowGoal;
  logic            boundary, lastRow, wrEnable;
  logic [COLS-1:0] orRow, compRow;
  logic [ROWS-1:0] dispNext;

  assign backSel  = ~frontSel;
  assign boundary = (prevAddr == AW'(COLS - 1)) && (SC_FRAMECOMP_dispAddr_In == '0);
  assign lastRow  = (scanRow == AW'(ROWS - 1));
  assign wrEnable = (state != PENDING);

  assign SC_FRAMECOMP_swapReady_Out   = (state == IDLE);
  assign SC_FRAMECOMP_swapPending_Out = (state == PENDING);

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge SC_FRAMECOMP_CLOCK_50 or negedge SC_FRAMECOMP_RESET_InLow) begin
    if (!SC_FRAMECOMP_RESET_InLow) state <= IDLE;
    else                           state <= nextState;
  end

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (SC_FRAMECOMP_swap_In) nextState = PENDING;
      PENDING: if (boundary)             nextState = SCAN;
      SCAN:    if (lastRow)              nextState = DONE;
      DONE:                              nextState = IDLE;
    endcase
  end

  // NOTE: the buffers are reset like ordinary state so the first displayed frame is blank, not X.
  always_ff @(posedge SC_FRAMECOMP_CLOCK_50 or negedge SC_FRAMECOMP_RESET_InLow) begin
    if (!SC_FRAMECOMP_RESET_InLow) begin
      frameBuf <= '0;
    end else if (wrEnable) begin
      for (int l = 0; l < LAYERS; l++)
        for (int r = 0; r < ROWS; r++)
          if (SC_FRAMECOMP_wrLayer_In[l] && SC_FRAMECOMP_wrRow_In == AW'(r))
            frameBuf[backSel][l][r] <= SC_FRAMECOMP_wrData_In;
    end
  end

  // Overlap test for the row under the scan counter, always on the current front frame.
  always_comb begin
    rowHit  = 1'b0;
    rowGoal = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (scanRow == AW'(r)) begin
        rowHit  = |(frameBuf[frontSel][0][r] & frameBuf[frontSel][1][r]);
        rowGoal = HAS_GOAL && |(frameBuf[frontSel][0][r] & frameBuf[frontSel][GOAL_LAYER][r]);
      end
    end
  end

  always_ff @(posedge SC_FRAMECOMP_CLOCK_50 or negedge SC_FRAMECOMP_RESET_InLow) begin
    if (!SC_FRAMECOMP_RESET_InLow) begin
      frontSel                   <= 1'b0;
      scanRow                    <= '0;
      hitAcc                     <= 1'b0;
      goalAcc                    <= 1'b0;
      SC_FRAMECOMP_checkDone_Out <= 1'b0;
      SC_FRAMECOMP_collision_Out <= 1'b0;
      SC_FRAMECOMP_goal_Out      <= 1'b0;
    end else begin
      SC_FRAMECOMP_checkDone_Out <= 1'b0;
      unique case (state)
        PENDING: if (boundary) begin
          frontSel <= ~frontSel;
          scanRow  <= '0;
          hitAcc   <= 1'b0;
          goalAcc  <= 1'b0;
        end
        SCAN: begin
          hitAcc  <= hitAcc | rowHit;
          goalAcc <= goalAcc | rowGoal;
          scanRow <= scanRow + 1'b1;
        end
        DONE: begin
          SC_FRAMECOMP_collision_Out <= hitAcc;
          SC_FRAMECOMP_goal_Out      <= goalAcc;
          SC_FRAMECOMP_checkDone_Out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transpose: row r of the composite frame becomes bit ROWS-1-r of the column word.
  always_comb begin
    dispNext = '0;
    orRow    = '0;
    compRow  = '0;
    for (int r = 0; r < ROWS; r++) begin
      orRow = '0;
      for (int l = 0; l < LAYERS; l++) orRow = orRow | frameBuf[frontSel][l][r];
      unique case (SC_FRAMECOMP_mode_In)
        2'b00: compRow = orRow;
        2'b01: compRow = frameBuf[frontSel][0][r];
        2'b10: compRow = '0;
        2'b11: compRow = ~orRow;
      endcase
      for (int a = 0; a < COLS; a++)
        if (SC_FRAMECOMP_dispAddr_In == AW'(a)) dispNext[ROWS-1-r] = compRow[COLS-1-a];
    end
  end

  always_ff @(posedge SC_FRAMECOMP_CLOCK_50 or negedge SC_FRAMECOMP_RESET_InLow) begin
    if (!SC_FRAMECOMP_RESET_InLow) begin
      SC_FRAMECOMP_dispData_Out <= '0;
      prevAddr                  <= '0;
    end else begin
      SC_FRAMECOMP_dispData_Out <= dispNext;
      prevAddr                  <= SC_FRAMECOMP_dispAddr_In;
    end
  end

endmodule

// File: tb/tb_sc_matrix_frame_compositor.sv
// Bench for sc_matrix_frame_compositor: display vectors from a table through a scoreboard queue,
// plus hand-written swap, scan-latency, drop/ignore and reset sequences.
module tb_sc_matrix_frame_compositor;

  logic       clk, rstN;
  logic [2:0] wrLayer, wrRow, dispAddr;
  logic [7:0] wrData, dispData;
  logic       swapIn;
  logic [1:0] mode;
  logic       swapReady, swapPending, checkDone, collision, goal;

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  typedef struct {
    int         grp;
    logic [1:0] mode;
    logic [2:0] addr;
    logic [7:0] exp;
  } vecT;

  vecT        vecs[$];
  logic [7:0] sbQ[$];

  sc_matrix_frame_compositor dut (
    .SC_FRAMECOMP_CLOCK_50       (clk),
    .SC_FRAMECOMP_RESET_InLow    (rstN),
    .SC_FRAMECOMP_wrLayer_In     (wrLayer),
    .SC_FRAMECOMP_wrRow_In       (wrRow),
    .SC_FRAMECOMP_wrData_In      (wrData),
    .SC_FRAMECOMP_swap_In        (swapIn),
    .SC_FRAMECOMP_mode_In        (mode),
    .SC_FRAMECOMP_dispAddr_In    (dispAddr),
    .SC_FRAMECOMP_dispData_Out   (dispData),
    .SC_FRAMECOMP_swapReady_Out  (swapReady),
    .SC_FRAMECOMP_swapPending_Out(swapPending),
    .SC_FRAMECOMP_checkDone_Out  (checkDone),
    .SC_FRAMECOMP_collision_Out  (collision),
    .SC_FRAMECOMP_goal_Out       (goal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic writeRow(input logic [2:0] mask, input logic [2:0] row, input logic [7:0] data);
    wrLayer = mask;
    wrRow   = row;
    wrData  = data;
    step();
    wrLayer = '0;
  endtask

  task automatic pulseSwap();
    swapIn = 1'b1;
    step();
    swapIn = 1'b0;
  endtask

  task automatic hitBoundary();
    dispAddr = 3'd7;
    step();
    dispAddr = 3'd0;
    step();
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (checkDone !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
    check("checkDone_seen", int'(checkDone), 1);
  endtask

  task automatic applyVec(input vecT v);
    logic [7:0] expd;
    mode     = v.mode;
    dispAddr = v.addr;
    sbQ.push_back(v.exp);
    step();
    expd = sbQ.pop_front();
    check($sformatf("disp g%0d m%0d a%0d", v.grp, v.mode, v.addr), int'(dispData), int'(expd));
  endtask

  task automatic runGroup(input int g);
    foreach (vecs[i]) if (vecs[i].grp == g) applyVec(vecs[i]);
  endtask

  initial begin
    // Group 2: front = {L0 row7 = 10}, mode OR
    for (int a = 0; a < 8; a++)
      vecs.push_back('{grp: 2, mode: 2'b00, addr: 3'(a), exp: (a == 3) ? 8'h01 : 8'h00});
    // Group 4: front = {L0 row0 = 01, L0 row7 = 10, L2 row0 = BB}
    vecs.push_back('{grp: 4, mode: 2'b01, addr: 3'd0, exp: 8'h00});
    vecs.push_back('{grp: 4, mode: 2'b01, addr: 3'd3, exp: 8'h01});
    vecs.push_back('{grp: 4, mode: 2'b01, addr: 3'd7, exp: 8'h80});
    vecs.push_back('{grp: 4, mode: 2'b00, addr: 3'd0, exp: 8'h80});
    vecs.push_back('{grp: 4, mode: 2'b00, addr: 3'd3, exp: 8'h81});
    vecs.push_back('{grp: 4, mode: 2'b00, addr: 3'd7, exp: 8'h80});
    vecs.push_back('{grp: 4, mode: 2'b11, addr: 3'd3, exp: 8'h7E});
    vecs.push_back('{grp: 4, mode: 2'b10, addr: 3'd3, exp: 8'h00});
    // Group 6: empty frame after reset
    for (int a = 0; a < 8; a++)
      vecs.push_back('{grp: 6, mode: 2'b11, addr: 3'(a), exp: 8'hFF});
    vecs.push_back('{grp: 6, mode: 2'b10, addr: 3'd0, exp: 8'h00});
    vecs.push_back('{grp: 6, mode: 2'b10, addr: 3'd5, exp: 8'h00});

    rstN = 1'b0; wrLayer = '0; wrRow = '0; wrData = '0;
    swapIn = 1'b0; mode = 2'b00; dispAddr = '0;
    step();
    step();
    check("rst swapReady",   int'(swapReady),   1);
    check("rst swapPending", int'(swapPending), 0);
    check("rst dispData",    int'(dispData),    0);
    check("rst collision",   int'(collision),   0);
    check("rst goal",        int'(goal),        0);
    check("rst checkDone",   int'(checkDone),   0);
    rstN = 1'b1;
    step();

    // Swap lands on the 7 -> 0 wrap of the second scan pass
    writeRow(3'b001, 3'd7, 8'h10);
    pulseSwap();
    check("t2 pending",   int'(swapPending), 1);
    check("t2 notReady",  int'(swapReady),   0);
    for (int a = 0; a < 8; a++) applyVec('{grp: 1, mode: 2'b00, addr: 3'(a), exp: 8'h00});
    runGroup(2);
    waitDone(cyc);
    check("t2 done tail",  cyc,              2);
    check("t2 collision",  int'(collision),  0);
    check("t2 goal",       int'(goal),       0);
    step();
    check("t2 done pulse", int'(checkDone),  0);
    check("t2 ready",      int'(swapReady),  1);

    // Write and swap in the same cycle; latency from boundary to checkDone
    writeRow(3'b001, 3'd4, 8'h20);
    wrLayer = 3'b010; wrRow = 3'd4; wrData = 8'h26; swapIn = 1'b1;
    step();
    wrLayer = '0; swapIn = 1'b0;
    hitBoundary();
    waitDone(cyc);
    check("t3 latency",   cyc,             9);
    check("t3 collision", int'(collision), 1);
    check("t3 goal",      int'(goal),      0);

    // Goal frame and layer0-only display
    writeRow(3'b001, 3'd0, 8'h01);
    writeRow(3'b100, 3'd0, 8'hBB);
    mode = 2'b01;
    pulseSwap();
    hitBoundary();
    check("t4 collision held", int'(collision), 1);
    waitDone(cyc);
    check("t4 goal",      int'(goal),      1);
    check("t4 collision", int'(collision), 0);
    runGroup(4);

    // Write during PENDING dropped; swap during SCAN ignored
    pulseSwap();
    check("t5 pending", int'(swapReady), 0);
    writeRow(3'b010, 3'd0, 8'hFF);
    check("t5 stillPending", int'(swapPending), 1);
    hitBoundary();
    check("t5 scan notReady", int'(swapReady), 0);
    pulseSwap();
    check("t5 swap ignored notReady", int'(swapReady), 0);
    waitDone(cyc);
    check("t5 collision", int'(collision), 1);
    check("t5 goal",      int'(goal),      0);
    step();
    step();
    check("t5 no queued swap", int'(swapPending), 0);
    check("t5 ready",          int'(swapReady),   1);
    applyVec('{grp: 5, mode: 2'b00, addr: 3'd0, exp: 8'h00});
    applyVec('{grp: 5, mode: 2'b00, addr: 3'd2, exp: 8'h08});

    // Asynchronous reset while a swap is pending
    pulseSwap();
    check("t1 pending pre-reset", int'(swapPending), 1);
    check("t1 disp pre-reset",    int'(dispData),    8'h08);
    rstN = 1'b0;
    #1;
    check("t1 rst swapReady",   int'(swapReady),   1);
    check("t1 rst swapPending", int'(swapPending), 0);
    check("t1 rst dispData",    int'(dispData),    0);
    check("t1 rst collision",   int'(collision),   0);
    step();
    check("t1 rst held ready", int'(swapReady), 1);
    rstN = 1'b1;
    step();

    runGroup(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
